bp_pkt_arbiter: RTL
===================

Name: bp_pkt_arbiter

Overview:
- Next-generation packet readout stage for the multi-engine correlator.
- Merges N_ENGINE per-engine packet FIFOs onto one BytePipe output stream.
- Arbitration is round-robin. Each packet transfers atomically. A per-engine enable mask gates which engines may be granted.
- Sits between the correlator engines' packet FIFOs and the host-facing BytePipe, replacing direct per-engine pops from the register block.

Parameters:
- N_ENGINE, 2: engine/FIFO count, 1..16.
- PKT_LEN, 8: bytes per packet, 1..255.
- ENGINE_W, $clog2(N_ENGINE) min 1: grant index width (derived; not overridden).

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_cg  input  1  clock-gate enable; low freezes all state.
- i_pktfifo_data  input  N_ENGINE*8  head byte of each FIFO.
- i_pktfifo_empty  input  N_ENGINE  per-FIFO empty.
- i_pktAvail  input  N_ENGINE  FIFO holds at least one complete packet.
- o_pktfifo_pop  output  N_ENGINE  per-FIFO pop, one-hot or zero.
- i_engineEn  input  N_ENGINE  arbitration mask.
- o_bp_data  output  8  BytePipe data.
- o_bp_valid  output  1  BytePipe valid.
- i_bp_ready  input  1  BytePipe ready.
- o_busy  output  1  packet in progress.
- o_grant  output  ENGINE_W  currently/last granted engine.
- o_underflow  output  1  one-cycle pulse: FIFO empty mid-packet.

Behaviour:
- Reset values: o_bp_data=0, o_bp_valid=0, o_pktfifo_pop=0, o_busy=0, o_grant=N_ENGINE-1 (so engine 0 wins first), o_underflow=0, state=IDLE, byteCnt=0.
- i_cg=0: no register updates, pops forced 0. Registered outputs hold, including o_bp_valid and o_bp_data.
- Output register: o_bp_data/o_bp_valid load when i_cg && (!o_bp_valid || i_bp_ready). A valid byte is never withdrawn or changed before the handshake.
- BytePipe transfer occurs on o_bp_valid && i_bp_ready.
- FSM states: IDLE, HDR (only with feature), BODY.
- IDLE:
  - req = i_pktAvail & i_engineEn.
  - If req != 0, choose the first set bit searching from o_grant+1 upward, wrapping modulo N_ENGINE.
  - Register o_grant, set o_busy=1, byteCnt=0, then go to BODY (or HDR).
  - If req == 0, stay in IDLE.
- BODY:
  - Load condition (load) = output register may load && !i_pktfifo_empty[o_grant].
  - On load: assert o_pktfifo_pop[o_grant] combinationally and load o_bp_data=i_pktfifo_data[o_grant] with valid=1.
  - Pop-to-valid latency is 1 cycle.
  - byteCnt increments per pop. When pop and byteCnt==PKT_LEN-1: go to IDLE with o_busy=0.
  - If the output register may load but the FIFO is empty: o_underflow pulses, o_bp_valid drops after any pending handshake, state is held (wait for data).
- Throughput: 1 byte/cycle inside a packet. One IDLE arbitration cycle between packets; the output register hides it when the downstream stalls.
- i_engineEn or i_pktAvail deasserting mid-packet has no effect; the packet completes.
- Only one engine is popped at a time; an engine is never popped outside its grant.
- N_ENGINE=1: arbitration is trivial; o_grant stays 0.
- PKT_LEN=1: BODY lasts exactly one pop.
- Asynchronous reset mid-packet: returns to IDLE immediately. The partial packet is abandoned; FIFO realignment is the register block's flush responsibility.

Optional Feature:
- Macro: BP_PKT_ARBITER_TAG_EN.
- Defined:
  - After a grant, state HDR loads the header byte {4'hA, grant zero-extended to 4 bits} into the output register, with no pop, under the same load rule.
  - Then the FSM goes to BODY. The packet on the wire is PKT_LEN+1 bytes.
- Undefined: HDR state and the header byte do not exist; IDLE goes directly to BODY.

Decomposition:
- Package bp_pkt_pkg:
  - state enum (IDLE/HDR/BODY).
  - TAG_NIBBLE=4'hA.
  - function for the engine index width.
  - PKT_LEN range-check constant.
- Sub-module rr_arbiter (N, request vector, last grant in, grant index + valid out, combinational) is natural and reusable.

Test Plan:
- N_ENGINE=4, PKT_LEN=4, all enabled, i_pktAvail=4'b1111, ready=1 -> packets leave in order 0,1,2,3,0; 4 bytes each, 1-cycle gap; pops one-hot to the matching FIFO.
- Only engine 2 available, then engine 1 becomes available mid-packet -> engine 2 packet completes intact; next grant is 1 (wrap search from 3).
- i_bp_ready toggling 1,0,0,1 during a packet -> o_bp_data stable while valid && !ready; no pop during stall; exactly PKT_LEN pops.
- i_engineEn=4'b0101, all available -> grants alternate 0,2,0,2; engines 1 and 3 never popped.
- FIFO empty after byte 2 of 4 -> o_underflow pulses; valid drops after handshake; resumes on refill; total 4 pops.
- BP_PKT_ARBITER_TAG_EN defined, engine 3 granted -> first byte 8'hA3, then 4 payload bytes; assert i_rstn=0 mid-packet -> outputs return to reset values next cycle.

Source files
------------

// File: rtl/bp_pkt_pkg.sv
// Shared types and constants for the BytePipe packet arbiter.
package bp_pkt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2
   } state_e;

   localparam logic [3:0] TAG_NIBBLE  = 4'hA;
   localparam int         PKT_LEN_MAX = 255;
   // Byte counter is sized for the largest legal packet, not the configured one.
   localparam int         CNT_W       = $clog2(PKT_LEN_MAX + 1);

   function automatic int engine_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request strictly after last_i, wrapping.
module rr_arbiter #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] grant_o,
   output logic         valid_o
);

   logic [W-1:0] idx_s;
   logic         hit_s;

   // Scan N positions starting one past the previous winner.
   always_comb begin
      grant_o = last_i;
      valid_o = 1'b0;
      idx_s   = last_i;
      hit_s   = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx_s   = W'((int'(last_i) + k) % N);
         hit_s   = !valid_o && req_i[idx_s];
         grant_o = hit_s ? idx_s : grant_o;
         valid_o = valid_o | hit_s;
      end
   end

endmodule

// File: rtl/bp_pkt_arbiter.sv
// Round-robin packet merger from N_ENGINE FIFOs onto one BytePipe stream.
// Optional header byte per packet when BP_PKT_ARBITER_TAG_EN is defined.
module bp_pkt_arbiter
   import bp_pkt_pkg::*;
#(
   parameter  int N_ENGINE = 2,
   parameter  int PKT_LEN  = 8,
   localparam int ENGINE_W = engine_w(N_ENGINE)
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_cg,
   input  logic [N_ENGINE*8-1:0] i_pktfifo_data,
   input  logic [N_ENGINE-1:0]   i_pktfifo_empty,
   input  logic [N_ENGINE-1:0]   i_pktAvail,
   output logic [N_ENGINE-1:0]   o_pktfifo_pop,
   input  logic [N_ENGINE-1:0]   i_engineEn,
   output logic [7:0]            o_bp_data,
   output logic                  o_bp_valid,
   input  logic                  i_bp_ready,
   output logic                  o_busy,
   output logic [ENGINE_W-1:0]   o_grant,
   output logic                  o_underflow
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ENGINE_W-1:0] grant_q, grant_d;
   logic                busy_q, busy_d;
   logic [7:0]          data_q, data_d;
   logic                valid_q, valid_d;
   logic                uflow_q, uflow_d;

   logic [7:0]          head_s [N_ENGINE];
   logic [N_ENGINE-1:0] req_s;
   logic [ENGINE_W-1:0] arb_grant_s;
   logic                arb_valid_s;
   logic                may_load_s;
   logic [N_ENGINE-1:0] pop_s;

   for (genvar g = 0; g < N_ENGINE; g++) begin : g_unpack
      assign head_s[g] = i_pktfifo_data[8*g +: 8];
   end

   assign req_s      = i_pktAvail & i_engineEn;
   assign may_load_s = i_cg && (!valid_q || i_bp_ready);

   rr_arbiter #(.N(N_ENGINE), .W(ENGINE_W)) u_rr (
      .req_i   (req_s),
      .last_i  (grant_q),
      .grant_o (arb_grant_s),
      .valid_o (arb_valid_s)
   );

   // Next-state, output-register and pop decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      busy_d  = busy_q;
      data_d  = data_q;
      valid_d = valid_q;
      uflow_d = 1'b0;
      pop_s   = '0;
      case (state_q)
         ST_IDLE: begin
            if (may_load_s) begin
               valid_d = 1'b0;
            end else begin
               valid_d = valid_q;
            end
            if (arb_valid_s) begin
               grant_d = arb_grant_s;
               busy_d  = 1'b1;
               cnt_d   = '0;
`ifdef BP_PKT_ARBITER_TAG_EN
               state_d = ST_HDR;
`else
               state_d = ST_BODY;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef BP_PKT_ARBITER_TAG_EN
         ST_HDR: begin
            if (may_load_s) begin
               data_d  = {TAG_NIBBLE, 4'(grant_q)};
               valid_d = 1'b1;
               state_d = ST_BODY;
            end else begin
               state_d = ST_HDR;
            end
         end
`endif
         ST_BODY: begin
            if (may_load_s && !i_pktfifo_empty[grant_q]) begin
               pop_s   = N_ENGINE'(1) << grant_q;
               data_d  = head_s[grant_q];
               valid_d = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(PKT_LEN - 1)) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_BODY;
               end
            end else if (may_load_s) begin
               // Starved mid-packet: drop valid once the held byte has gone, keep waiting.
               uflow_d = 1'b1;
               valid_d = 1'b0;
            end else begin
               state_d = ST_BODY;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; i_cg low freezes everything.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         grant_q <= ENGINE_W'(N_ENGINE - 1);
         busy_q  <= 1'b0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         uflow_q <= 1'b0;
      end else if (i_cg) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         uflow_q <= uflow_d;
      end
   end

   assign o_pktfifo_pop = pop_s;
   assign o_bp_data     = data_q;
   assign o_bp_valid    = valid_q;
   assign o_busy        = busy_q;
   assign o_grant       = grant_q;
   assign o_underflow   = uflow_q;

endmodule
